logic_net_pipe: RTL and testbench

//  Bit-parallel, pipelined generalisation of the five-input logic network: WIDTH independent lanes, same equations per lane.
//  Two registered stages with valid/ready handshake on both sides, plus a saturating event counter.

---
 rtl/logic_net_pipe.sv | 117 +++++++++++
 tb/tb_logic_net_pipe.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_net_pipe.sv
// Five-input logic network on WIDTH parallel lanes behind two register stages, 2-cycle latency, 1 beat/cycle.
// Valid/ready on both sides; a stalled consumer holds o/p/q stable, fills both stages, then drops in_ready.
module logic_net_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] e,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] o,
   output logic [WIDTH-1:0] p,
   output logic [WIDTH-1:0] q,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] o_cnt
);

   typedef struct packed {
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] h;
      logic [WIDTH-1:0] i;
      logic [WIDTH-1:0] j;
      logic [WIDTH-1:0] b;
   } s1_t;

   typedef struct packed {
      logic [WIDTH-1:0] o;
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] q;
   } s2_t;

   s1_t              s1_q, s1_d;
   s2_t              s2_q, s2_d;
   logic             s1_vld_q, s1_vld_d;
   logic             s2_vld_q, s2_vld_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             s2_load, s1_load, in_xfer, out_xfer;
   logic [WIDTH-1:0] k, l, m, n;

   always_comb begin
      s2_load  = !s2_vld_q || out_ready;
      s1_load  = !s1_vld_q || s2_load;
      in_xfer  = in_valid && s1_load;
      out_xfer = s2_vld_q && out_ready;

      s1_d     = s1_q;
      s1_vld_d = s1_vld_q;
      if (s1_load) begin
         s1_vld_d = in_valid;
      end
      if (in_xfer) begin
         s1_d.g = a | d;
         s1_d.h = a & c;
         s1_d.i = ~c;
         s1_d.j = d | e;
         s1_d.b = b;
      end

      // n is kept structurally even though it always folds to zero
      k = s1_q.g | s1_q.h;
      l = s1_q.h & s1_q.j;
      m = s1_q.i & s1_q.j;
      n = l & m;

      s2_d     = s2_q;
      s2_vld_d = s2_vld_q;
      if (s2_load) begin
         s2_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            s2_d.o = s1_q.b & k;
            s2_d.p = ~s1_q.g;
            s2_d.q = ~n;
         end
      end

      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (out_xfer && (s2_q.o != '0) && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q     <= '0;
         s2_q     <= '0;
         s1_vld_q <= 1'b0;
         s2_vld_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         s1_vld_q <= s1_vld_d;
         s2_vld_q <= s2_vld_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      in_ready  = s1_load;
      out_valid = s2_vld_q;
      o         = s2_q.o;
      p         = s2_q.p;
      q         = s2_q.q;
      o_cnt     = cnt_q;
   end

endmodule

// File: tb/tb_logic_net_pipe.sv
// Randomized and directed bench for logic_net_pipe against a queue-based reference model.
// A second instance with a 2-bit counter exercises counter saturation on the same stimulus.
module tb_logic_net_pipe;

   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready, cnt_clr;
   logic [7:0]  a, b, c, d, e;
   logic        in_ready, out_valid, in_ready2, out_valid2;
   logic [7:0]  o, p, q, o2, p2, q2;
   logic [15:0] o_cnt;
   logic [1:0]  o_cnt2;

   always #5 clk = ~clk;

   logic_net_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c(c), .d(d), .e(e),
      .out_valid(out_valid), .out_ready(out_ready), .o(o), .p(p), .q(q),
      .cnt_clr(cnt_clr), .o_cnt(o_cnt)
   );

   logic_net_pipe #(.WIDTH(8), .CNT_W(2)) u_dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .a(a), .b(b), .c(c), .d(d), .e(e),
      .out_valid(out_valid2), .out_ready(out_ready), .o(o2), .p(p2), .q(q2),
      .cnt_clr(cnt_clr), .o_cnt(o_cnt2)
   );

   typedef struct {
      logic [7:0] o;
      logic [7:0] p;
      logic [7:0] q;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   mcnt = 0;
   int   mcnt2 = 0;
   int   nout = 0;
   bit   acc = 1'b0;
   bit   stall_prev = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: g=a|d, and n cancels to zero, so q is constant all-ones.
   function automatic exp_t model(input logic [7:0] a_i, input logic [7:0] b_i, input logic [7:0] d_i);
      exp_t r;
      r.o = b_i & (a_i | d_i);
      r.p = ~(a_i | d_i);
      r.q = 8'hFF;
      return r;
   endfunction

   // Observe outputs and predict what the coming clock edge does.
   always @(negedge clk) begin
      bit oxfer;
      acc = 1'b0;
      if (rst) begin
         exp_q.delete();
         mcnt       = 0;
         mcnt2      = 0;
         stall_prev = 1'b0;
      end else begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
               chk("o", 64'(o), 64'(exp_q[0].o));
               chk("p", 64'(p), 64'(exp_q[0].p));
               chk("q", 64'(q), 64'(exp_q[0].q));
            end
         end
         if (stall_prev) chk("stall_hold_valid", 64'(out_valid), 64'd1);
         chk("in_ready", 64'(in_ready), 64'((exp_q.size() < 2) || out_ready));
         chk("o_cnt", 64'(o_cnt), 64'(mcnt));
         chk("o_cnt_sat", 64'(o_cnt2), 64'(mcnt2));
         oxfer = out_valid && out_ready && (exp_q.size() > 0);
         if (cnt_clr) begin
            mcnt  = 0;
            mcnt2 = 0;
         end else if (oxfer && exp_q[0].o != 8'h00) begin
            if (mcnt < 65535) mcnt++;
            if (mcnt2 < 3) mcnt2++;
         end
         if (oxfer) begin
            void'(exp_q.pop_front());
            nout++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, d));
            acc = 1'b1;
         end
         stall_prev = out_valid && !out_ready;
      end
   end

   task automatic step();
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic rand_beat();
      a = 8'($urandom);
      b = 8'($urandom);
      c = 8'($urandom);
      d = 8'($urandom);
      e = 8'($urandom);
   endtask

   task automatic set_beat(input logic [7:0] ai, bi, ci, di, ei);
      a = ai; b = bi; c = ci; d = di; e = ei;
   endtask

   initial begin
      int base, accepts;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
      set_beat(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      @(posedge clk); #1;
      step(); step();
      rst = 1'b0;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_opq", 64'({o, p, q}), 64'd0);
      chk("rst_o_cnt", 64'(o_cnt), 64'd0);

      // Directed beat 1: two cycles to the output, counts as o != 0
      set_beat(8'hF0, 8'hFF, 8'hCC, 8'h0F, 8'h00);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("lat_not_yet", 64'(out_valid), 64'd0);
      step();
      chk("lat_valid", 64'(out_valid), 64'd1);
      chk("dir1_opq", 64'({o, p, q}), 64'h00FF_00FF);
      step();
      chk("dir1_cnt", 64'(o_cnt), 64'd1);

      // Directed beat 2: o == 0 leaves the counter alone
      set_beat(8'h00, 8'hAA, 8'h00, 8'h00, 8'hFF);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk("dir2_opq", 64'({o, p, q}), 64'h0000_FFFF);
      step();
      chk("dir2_cnt", 64'(o_cnt), 64'd1);

      // Stream 10 beats back to back
      base = nout;
      for (int i = 0; i < 10; i++) begin
         rand_beat();
         in_valid = 1'b1;
         step();
         chk("stream_accept", 64'(acc), 64'd1);
      end
      in_valid = 1'b0;
      step(); step();
      chk("stream_throughput", 64'(nout - base), 64'd10);

      // Stall: consumer blocked, only two beats fit
      out_ready = 1'b0;
      accepts = 0;
      rand_beat();
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         if (acc) begin
            accepts++;
            rand_beat();
         end
      end
      chk("stall_accepts", 64'(accepts), 64'd2);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) step();
      chk("stall_drain", 64'(exp_q.size()), 64'd0);

      // Random traffic with random back-pressure and occasional clears
      rand_beat();
      in_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!in_valid || acc) begin
            rand_beat();
            in_valid = ($urandom_range(0, 3) != 0);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         cnt_clr   = ($urandom_range(0, 31) == 0);
         step();
      end
      in_valid = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
      repeat (4) step();
      chk("random_drain", 64'(exp_q.size()), 64'd0);

      // Saturation of the 2-bit counter
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rand_beat();
         a = 8'hFF; b = 8'hFF;
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      repeat (3) step();
      chk("sat_cnt2", 64'(o_cnt2), 64'd3);
      chk("sat_cnt16", 64'(o_cnt), 64'd5);

      // Clear wins over a coincident increment
      set_beat(8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk("clr_out_valid", 64'(out_valid), 64'd1);
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      chk("clr_prio", 64'(o_cnt), 64'd0);
      chk("clr_prio_sat", 64'(o_cnt2), 64'd0);

      // Reset with two beats in flight and a nonzero counter
      set_beat(8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (2) step();
      chk("pre_rst_cnt", 64'(o_cnt), 64'd1);
      in_valid = 1'b1;
      rand_beat();
      step();
      rand_beat();
      step();
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_opq", 64'({o, p, q}), 64'd0);
      chk("mid_rst_cnt", 64'(o_cnt), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_no_valid", 64'(out_valid), 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
